uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16, ticks per bit period; SHALL be even and >= 4.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  one-clk-wide oversample strobe from the baud generator, OVERSAMPLE per bit period.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 rx_data  output  DATA_BITS  last received word, LSB = first data bit.
REQ-008 rx_valid  output  1  one-clk pulse: good frame received, rx_data updated.
REQ-009 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; rx_s denotes the synchronized value.
REQ-012 FSM states SHALL be exactly IDLE, START, DATA and STOP.
REQ-013 A tick counter tcnt, width clog2(OVERSAMPLE), SHALL advance only on clk edges where tick=1.
REQ-014 IDLE: on any clk where rx_s=0 and the previous rx_s=1, go to START with tcnt=0; a held-low line SHALL NOT retrigger.
REQ-015 START: on the tick where tcnt=OVERSAMPLE/2-1, if rx_s=0 go to DATA with tcnt=0 and bit index=0; otherwise return to IDLE as a glitch, with no output pulse.
REQ-016 DATA: on the tick where tcnt=OVERSAMPLE-1, shift rx_s into the MSB of a shift register (right shift), clear tcnt and increment the bit index.
REQ-017 DATA: after sampling bit DATA_BITS-1, go to STOP with tcnt=0.
REQ-018 STOP: on the tick where tcnt=OVERSAMPLE-1, copy the shift register to rx_data and go to IDLE.
REQ-019 At the STOP sample, rx_s=1 SHALL pulse rx_valid; rx_s=0 SHALL pulse frame_err; the two are never high together.
REQ-020 The rx_valid/frame_err pulse SHALL be registered, high for exactly the one clk following the STOP sample edge.
REQ-021 rx_data SHALL hold its value between frames and SHALL be updated on frame error as well.
REQ-022 tick=0 SHALL freeze tcnt and all state.
REQ-023 A falling edge arriving in the same clk as the return to IDLE SHALL be detected on the next clk; back-to-back frames with a one-bit stop SHALL be received without loss.

Reset
REQ-024 rst_n=0 SHALL immediately force:
- state=IDLE
- tcnt=0, bit index=0
- shift register=0, rx_data=0
- rx_valid=0, frame_err=0, busy=0
- both synchronizer flops and the edge-detect flop=1
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no pulse; reception resumes at the first falling edge after release.

Structure
REQ-026 A shared package uart_pkg SHALL hold the FSM state encoding and the default DATA_BITS/OVERSAMPLE constants, reused by the future transmitter.
REQ-027 The synchronizer SHALL be a sub-module sync_2ff (1-bit, reset value parameter = 1).
REQ-028 The baud generator SHALL NOT be instantiated inside uart_rx; tick is a port.

Verification (50 MHz clk; generator tick every 325 clk, so 1 bit = 5200 clk)
REQ-029 Frame 0x55 (start, 10101010 LSB-first, stop=1) -> one rx_valid pulse, rx_data=0x55, frame_err=0.
REQ-030 Back-to-back 0xA3 then 0x0F with one stop bit -> two rx_valid pulses; rx_data=0xA3, then 0x0F.
REQ-031 Frame 0xFF with stop bit forced low -> frame_err pulse, rx_valid=0, rx_data=0xFF; a line held low afterwards produces no new frame.
REQ-032 Low glitch of 2000 clk on an idle line -> returns to IDLE, no pulse, busy falls within 5200 clk.
REQ-033 rst_n pulsed low during data bit 4 of 0x3C -> all outputs 0 immediately, no pulse; the next 0x3C frame is received correctly.
REQ-034 tick held 0 for 10000 clk mid-frame with the rx line stretched to match -> frame still received correctly (0x81).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame constants,
// common to the receiver and the future transmitter.
package uart_pkg;

    // Default number of data bits per frame.
    localparam int UART_DATA_BITS  = 8;

    // Default oversample ticks per bit period (must be even and >= 4).
    localparam int UART_OVERSAMPLE = 16;

    // Serial line level while no frame is in progress.
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Frame-level FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a
// configurable value loaded on reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop framing driven by an
// external tick strobe. Emits a one-clk rx_valid or frame_err pulse
// per completed frame and keeps the last word on rx_data.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Tick count at the middle of the start bit, and at one full bit period.
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 r_rx_prev;
    logic                 w_rx_prev_next;
    logic                 w_fall;

    uart_state_e          r_state;
    uart_state_e          w_state_next;
    logic [TW-1:0]        r_tcnt;
    logic [TW-1:0]        w_tcnt_next;
    logic [BW-1:0]        r_bidx;
    logic [BW-1:0]        w_bidx_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;

    logic                 w_busy;
    logic                 w_stop_sample;

    sync_2ff #(
        .RESET_VAL (UART_IDLE_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // High-to-low transition of the synchronized line.
    assign w_fall = r_rx_prev & ~w_rx_s;

    // State register plus the frame datapath (tick counter, bit index, shifter, edge flop).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_tcnt    <= '0;
            r_bidx    <= '0;
            r_shift   <= '0;
            r_rx_prev <= UART_IDLE_LEVEL;
        end else begin
            r_state   <= w_state_next;
            r_tcnt    <= w_tcnt_next;
            r_bidx    <= w_bidx_next;
            r_shift   <= w_shift_next;
            r_rx_prev <= w_rx_prev_next;
        end
    end

    // Next-state and datapath-next logic; everything except edge detection waits for tick.
    always_comb begin
        w_state_next = r_state;
        w_tcnt_next  = r_tcnt;
        w_bidx_next  = r_bidx;
        w_shift_next = r_shift;

        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_next = START;
                    w_tcnt_next  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (r_tcnt == T_HALF) begin
                        w_tcnt_next = '0;
                        if (!w_rx_s) begin
                            w_state_next = DATA;
                            w_bidx_next  = '0;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_tcnt_next = r_tcnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (r_tcnt == T_FULL) begin
                        w_tcnt_next  = '0;
                        w_shift_next = DATA_BITS'({w_rx_s, r_shift} >> 1);
                        if (r_bidx == B_LAST) begin
                            w_state_next = STOP;
                            w_bidx_next  = '0;
                        end else begin
                            w_bidx_next  = r_bidx + 1'b1;
                        end
                    end else begin
                        w_tcnt_next = r_tcnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (r_tcnt == T_FULL) begin
                        w_state_next = IDLE;
                        w_tcnt_next  = '0;
                    end else begin
                        w_tcnt_next = r_tcnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tcnt_next  = '0;
                w_bidx_next  = '0;
            end
        endcase

        // An edge seen on the very clk we fall back to IDLE is kept pending by
        // holding the edge flop high, so IDLE still sees it one clk later.
        // A line that was already low stays low in the flop: no retrigger.
        if ((r_state != IDLE) && (w_state_next == IDLE) && w_fall) begin
            w_rx_prev_next = 1'b1;
        end else begin
            w_rx_prev_next = w_rx_s;
        end
    end

    // Output decode from the current state.
    always_comb begin
        w_busy        = (r_state != IDLE);
        w_stop_sample = (r_state == STOP) && tick && (r_tcnt == T_FULL);
    end

    // Registered frame result: one-clk pulse and word capture at the stop sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= w_stop_sample & w_rx_s;
            r_frame_err <= w_stop_sample & ~w_rx_s;
            if (w_stop_sample) begin
                r_rx_data <= r_shift;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = w_busy;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx.
module tb_uart_rx;

    localparam int TICK_DIV = 8;
    localparam int OS       = 16;
    localparam int BIT      = OS * TICK_DIV;
    localparam int GLITCH   = 48;
    localparam int PAUSE    = 300;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       tick;
    logic       tick_en = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int tdiv    = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_ferr  = 0;
    int n_both  = 0;
    int n_long  = 0;
    int run_len = 0;
    logic [7:0] cap[$];

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (OS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    // Baud tick source: one-clk strobe every TICK_DIV clks, gated by tick_en.
    always @(posedge clk) tdiv <= (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
    assign tick = tick_en && (tdiv == TICK_DIV - 1);

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid = n_valid + 1;
            cap.push_back(rx_data);
        end
        if (frame_err) n_ferr = n_ferr + 1;
        if (rx_valid && frame_err) n_both = n_both + 1;
        if (rx_valid || frame_err) run_len = run_len + 1;
        else run_len = 0;
        if (run_len > 1) n_long = n_long + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame LSB-first; rx is left at the stop level afterwards.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int stretch_bit, input int pause);
        $display("[TB] send frame 0x%02h stop=%0d", d, stop);
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == stretch_bit) begin
                wait_clks(BIT / 2);
                tick_en = 1'b0;
                wait_clks(pause);
                tick_en = 1'b1;
                wait_clks(BIT - BIT / 2);
            end else begin
                wait_clks(BIT);
            end
        end
        rx = stop;
        wait_clks(BIT);
    endtask

    int base_v;
    int base_f;
    int k;

    initial begin
        // Reset state
        wait_clks(5);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        wait_clks(2 * BIT);

        // Single good frame 0x55
        base_v = n_valid; base_f = n_ferr;
        send_frame(8'h55, 1'b1, -1, 0);
        wait_clks(BIT);
        check("f55_valid_cnt", n_valid - base_v, 1);
        check("f55_ferr_cnt", n_ferr - base_f, 0);
        check("f55_cap", 32'(cap[cap.size()-1]), 32'h55);
        check("f55_rx_data", 32'(rx_data), 32'h55);
        check("f55_busy", 32'(busy), 32'h0);

        // Back-to-back 0xA3, 0x0F with one stop bit
        base_v = n_valid; base_f = n_ferr;
        send_frame(8'hA3, 1'b1, -1, 0);
        send_frame(8'h0F, 1'b1, -1, 0);
        wait_clks(BIT);
        check("b2b_valid_cnt", n_valid - base_v, 2);
        check("b2b_ferr_cnt", n_ferr - base_f, 0);
        check("b2b_first", 32'(cap[base_v]), 32'hA3);
        check("b2b_second", 32'(cap[base_v+1]), 32'h0F);
        check("b2b_rx_data", 32'(rx_data), 32'h0F);

        // 0xFF with stop bit low, line then held low
        base_v = n_valid; base_f = n_ferr;
        send_frame(8'hFF, 1'b0, -1, 0);
        wait_clks(3 * BIT);
        check("ferr_cnt", n_ferr - base_f, 1);
        check("ferr_valid_cnt", n_valid - base_v, 0);
        check("ferr_rx_data", 32'(rx_data), 32'hFF);
        check("ferr_held_low_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        wait_clks(2 * BIT);
        check("ferr_after_release_ferr", n_ferr - base_f, 1);

        // Short low glitch on an idle line
        $display("[TB] glitch %0d clk", GLITCH);
        base_v = n_valid; base_f = n_ferr;
        rx = 1'b0;
        wait_clks(10);
        check("glitch_busy_hi", 32'(busy), 32'h1);
        wait_clks(GLITCH - 10);
        rx = 1'b1;
        k = 0;
        while (busy && k < BIT) begin
            wait_clks(1);
            k++;
        end
        check("glitch_busy_fall", 32'(busy), 32'h0);
        wait_clks(BIT);
        check("glitch_valid_cnt", n_valid - base_v, 0);
        check("glitch_ferr_cnt", n_ferr - base_f, 0);
        check("glitch_rx_data", 32'(rx_data), 32'hFF);

        // Reset pulsed during data bit 4 of 0x3C
        $display("[TB] reset during frame 0x3c bit 4");
        base_v = n_valid; base_f = n_ferr;
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = (i >= 2) ? 1'b1 : 1'b0;
            wait_clks(BIT);
        end
        rx = 1'b1;
        wait_clks(BIT / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_rx_data", 32'(rx_data), 32'h0);
        check("midrst_rx_valid", 32'(rx_valid), 32'h0);
        check("midrst_frame_err", 32'(frame_err), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        wait_clks(3);
        rst_n = 1'b1;
        rx = 1'b1;
        wait_clks(12 * BIT);
        check("midrst_no_valid", n_valid - base_v, 0);
        check("midrst_no_ferr", n_ferr - base_f, 0);
        send_frame(8'h3C, 1'b1, -1, 0);
        wait_clks(BIT);
        check("f3c_valid_cnt", n_valid - base_v, 1);
        check("f3c_rx_data", 32'(rx_data), 32'h3C);

        // tick frozen mid-frame with the line stretched to match
        base_v = n_valid; base_f = n_ferr;
        send_frame(8'h81, 1'b1, 3, PAUSE);
        wait_clks(BIT);
        check("f81_valid_cnt", n_valid - base_v, 1);
        check("f81_ferr_cnt", n_ferr - base_f, 0);
        check("f81_rx_data", 32'(rx_data), 32'h81);

        // Pulse shape over the whole run
        check("pulse_overlap", n_both, 0);
        check("pulse_width", n_long, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_rx
